// File: rtl/fp_wb_stage.sv
// fp_wb_stage
//   Sequencing and writeback stage that sits after the FP execute stage.
//   It accepts one FP operation at a time and keeps the execute stage
//   enabled for the operation's latency. When the result is valid it samples
//   fp_result/fflags and issues a registered one-cycle writeback. It also
//   holds the sticky accrued-exception (fflags) CSR field.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no operation in flight; issue accepted unless flushed
//   BUSY  | operation in flight; cnt counts down to its result cycle
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   issue_valid/latency/rd/fp_to_int operation presented by decode
//   flush                            kill in-flight or issuing operation
//   fp_result, fflags                execute stage result and flags
//   csr_fflags_we/wdata              CSR write to the accrued flags
//   exec_enable                      execute stage enable
//   issue_ready, stall               issue handshake / pipeline stall
//   wb_valid/rd/data/to_int          registered one-cycle writeback
//   fflags_accrued                   sticky exception flags (NV,DZ,OF,UF,NX)
module fp_wb_stage #(
  parameter int XLEN  = 32,
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [LAT_W-1:0] issue_latency,
  input  logic [4:0]       issue_rd,
  input  logic             issue_fp_to_int,
  input  logic             flush,
  input  logic [XLEN-1:0]  fp_result,
  input  logic [4:0]       fflags,
  input  logic             csr_fflags_we,
  input  logic [4:0]       csr_fflags_wdata,
  output logic             exec_enable,
  output logic             issue_ready,
  output logic             stall,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_to_int,
  output logic [4:0]       fflags_accrued
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [LAT_W-1:0] CNT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [LAT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       rd_q;
  logic             to_int_q;

  logic             accept;
  logic             lat_zero;
  logic             busy_done;
  logic             capture;
  logic [4:0]       cap_rd;
  logic             cap_to_int;
  logic [4:0]       fflags_base;

  assign issue_ready = (state == IDLE) & ~flush;
  assign stall       = issue_valid & ~issue_ready;
  assign exec_enable = ((state == IDLE) & issue_valid & ~flush) | (state == BUSY);

  assign accept    = issue_valid & issue_ready;
  assign lat_zero  = (issue_latency == '0);
  // Terminal count: the result is valid in the cycle cnt reads 1. A flush
  // landing in that same cycle suppresses the capture.
  assign busy_done = (state == BUSY) & (cnt == CNT_ONE) & ~flush;
  assign capture   = (accept & lat_zero) | busy_done;

  // Latency-0 operations write back straight from the issue fields.
  assign cap_rd     = busy_done ? rd_q     : issue_rd;
  assign cap_to_int = busy_done ? to_int_q : issue_fp_to_int;

  // A CSR write replaces the accrued value but still merges flags captured
  // in the same cycle.
  assign fflags_base = csr_fflags_we ? csr_fflags_wdata : fflags_accrued;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept && !lat_zero) begin
          state_nxt = BUSY;
          cnt_nxt   = issue_latency;
        end
      end
      BUSY: begin
        if (flush) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      to_int_q <= 1'b0;
    end else if (accept && !lat_zero) begin
      rd_q     <= issue_rd;
      to_int_q <= issue_fp_to_int;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      wb_to_int      <= 1'b0;
      fflags_accrued <= '0;
    end else begin
      wb_valid       <= capture;
      fflags_accrued <= fflags_base | (capture ? fflags : 5'b0);
      if (capture) begin
        wb_rd     <= cap_rd;
        wb_data   <= fp_result;
        wb_to_int <= cap_to_int;
      end
    end
  end

endmodule
